// File: rtl/oled_spi_receiver.sv
// oled_spi_receiver: oversampled SPI mode-3 receiver for the PmodOLEDrgb link,
// tagging bytes as command/data and tracking display on/off and byte counts.
module oled_spi_receiver #(
  parameter int         CNT_W   = 16,
  parameter logic [7:0] ON_CMD  = 8'hAF,
  parameter logic [7:0] OFF_CMD = 8'hAE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             spi_clk,
  input  logic             spi_mosi,
  input  logic             spi_cs,
  input  logic             spi_dc,
  output logic [7:0]       rx_byte,
  output logic             rx_dc,
  output logic             rx_valid,
  output logic             frame_err,
  output logic             display_on,
  output logic [CNT_W-1:0] cmd_count,
  output logic [CNT_W-1:0] data_count
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state_q, state_d;
  logic [1:0] sclk_q, cs_q, mosi_q, dc_q;
  logic sclk_prev_q;
  logic [2:0] cnt_q, cnt_d, cnt_nx;
  logic [6:0] shift_q, shift_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic rx_dc_q, rx_dc_d, rx_valid_q, rx_valid_d, frame_err_q, frame_err_d;
  logic display_q, display_d;
  logic [CNT_W-1:0] cmd_q, cmd_d, data_q, data_d;
  logic rise, take, done, cs_rise;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_q      <= 2'b11;
      sclk_prev_q <= 1'b1;
      cs_q        <= 2'b11;
      mosi_q      <= 2'b00;
      dc_q        <= 2'b00;
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      rx_byte_q   <= '0;
      rx_dc_q     <= 1'b0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      display_q   <= 1'b0;
      cmd_q       <= '0;
      data_q      <= '0;
    end else begin
      sclk_q      <= {sclk_q[0], spi_clk};
      sclk_prev_q <= sclk_q[1];
      cs_q        <= {cs_q[0], spi_cs};
      mosi_q      <= {mosi_q[0], spi_mosi};
      dc_q        <= {dc_q[0], spi_dc};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      rx_byte_q   <= rx_byte_d;
      rx_dc_q     <= rx_dc_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      display_q   <= display_d;
      cmd_q       <= cmd_d;
      data_q      <= data_d;
    end
  end
  // An edge coinciding with CS release still counts, so a just-finished byte is not lost.
  always_comb begin
    rise        = sclk_q[1] & ~sclk_prev_q;
    take        = rise & (~cs_q[1] | state_q == SHIFT);
    cs_rise     = state_q == SHIFT & cs_q[1];
    cnt_nx      = take ? cnt_q + 3'd1 : cnt_q;
    done        = take & cnt_q == 3'd7;
    cnt_d       = cs_rise ? 3'd0 : cnt_nx;
    state_d     = cs_q[1] ? IDLE : SHIFT;
    shift_d     = take ? {shift_q[5:0], mosi_q[1]} : shift_q;
    rx_byte_d   = done ? {shift_q, mosi_q[1]} : rx_byte_q;
    rx_dc_d     = done ? dc_q[1] : rx_dc_q;
    rx_valid_d  = done;
    frame_err_d = cs_rise & cnt_nx != 3'd0;
    display_d   = (rx_valid_q & ~rx_dc_q & rx_byte_q == ON_CMD)  ? 1'b1 :
                  (rx_valid_q & ~rx_dc_q & rx_byte_q == OFF_CMD) ? 1'b0 : display_q;
    cmd_d       = (rx_valid_q & ~rx_dc_q) ? cmd_q + 1'b1 : cmd_q;
    data_d      = (rx_valid_q & rx_dc_q) ? data_q + 1'b1 : data_q;
  end
  assign rx_byte    = rx_byte_q;
  assign rx_dc      = rx_dc_q;
  assign rx_valid   = rx_valid_q;
  assign frame_err  = frame_err_q;
  assign display_on = display_q;
  assign cmd_count  = cmd_q;
  assign data_count = data_q;
endmodule

// File: tb/tb_oled_spi_receiver.sv
// tb_oled_spi_receiver: directed SPI traffic checked cycle-by-cycle against a
// transaction-level model (expected byte events with due cycles and running counts).
module tb_oled_spi_receiver;
  logic clk = 1'b0, rst_n = 1'b0;
  logic spi_clk = 1'b1, spi_mosi = 1'b0, spi_cs = 1'b1, spi_dc = 1'b0;
  logic [7:0] rx_byte, rx_byte4;
  logic rx_dc, rx_valid, frame_err, display_on;
  logic rx_dc4, rx_valid4, frame_err4, display_on4;
  logic [15:0] cmd_count, data_count;
  logic [3:0] cmd_count4, data_count4;
  int cyc = 0, vectors = 0, miscompares = 0, nvalid = 0, nfe = 0;
  typedef struct { int due; logic [7:0] b; logic dc; } ev_t;
  ev_t evq[$];
  int feq[$];
  int m_cmd = 0, m_data = 0;
  logic m_on = 1'b0, m_dc = 1'b0;
  logic [7:0] m_b = 8'h00;
  oled_spi_receiver dut (
    .clk(clk), .reset(rst_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_cs(spi_cs),
    .spi_dc(spi_dc), .rx_byte(rx_byte), .rx_dc(rx_dc), .rx_valid(rx_valid),
    .frame_err(frame_err), .display_on(display_on), .cmd_count(cmd_count), .data_count(data_count));
  oled_spi_receiver #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(rst_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_cs(spi_cs),
    .spi_dc(spi_dc), .rx_byte(rx_byte4), .rx_dc(rx_dc4), .rx_valid(rx_valid4),
    .frame_err(frame_err4), .display_on(display_on4), .cmd_count(cmd_count4), .data_count(data_count4));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", n, cyc, act, exp);
    end
  endtask
  // Model: a byte completed at the pin-level rising edge in cycle C appears at C+3.
  initial forever begin
    logic ev, fe;
    @(negedge clk); #1;
    if (!rst_n) begin
      evq.delete(); feq.delete();
      m_cmd = 0; m_data = 0; m_on = 1'b0; m_b = 8'h00; m_dc = 1'b0;
    end
    while (evq.size() > 0 && evq[0].due < cyc) evq.delete(0);
    while (feq.size() > 0 && feq[0] < cyc) feq.delete(0);
    ev = evq.size() > 0 && evq[0].due == cyc;
    fe = feq.size() > 0 && feq[0] == cyc;
    chk("cmd_count", 32'(cmd_count), 32'(m_cmd % 65536));
    chk("data_count", 32'(data_count), 32'(m_data % 65536));
    chk("data_count_w4", 32'(data_count4), 32'(m_data % 16));
    chk("cmd_count_w4", 32'(cmd_count4), 32'(m_cmd % 16));
    chk("display_on", 32'(display_on), 32'(m_on));
    if (ev) begin
      m_b = evq[0].b; m_dc = evq[0].dc; evq.delete(0);
    end
    if (fe) feq.delete(0);
    chk("rx_valid", 32'(rx_valid), 32'(ev));
    chk("frame_err", 32'(frame_err), 32'(fe));
    chk("rx_byte", 32'(rx_byte), 32'(m_b));
    chk("rx_dc", 32'(rx_dc), 32'(m_dc));
    if (rx_valid === 1'b1) nvalid++;
    if (frame_err === 1'b1) nfe++;
    if (ev && !m_dc) begin
      m_cmd++;
      if (m_b == 8'hAF) m_on = 1'b1;
      if (m_b == 8'hAE) m_on = 1'b0;
    end
    if (ev && m_dc) m_data++;
  end
  task automatic send_bits(input logic [7:0] b, input logic dc, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      @(negedge clk); spi_clk = 1'b0; spi_mosi = b[i]; spi_dc = dc;
      repeat (3) @(negedge clk);
      @(negedge clk); spi_clk = 1'b1;
      if (i == 0) evq.push_back('{cyc + 3, b, dc});
      repeat (3) @(negedge clk);
    end
  endtask
  task automatic cs_low();
    @(negedge clk); spi_cs = 1'b0;
    repeat (4) @(negedge clk);
  endtask
  task automatic cs_high(input logic partial);
    @(negedge clk); spi_cs = 1'b1;
    if (partial) feq.push_back(cyc + 3);
    repeat (6) @(negedge clk);
  endtask
  task automatic settle();
    repeat (8) @(negedge clk);
    #2;
  endtask
  initial begin
    #100;
    @(negedge clk); rst_n = 1'b1;
    repeat (1000) @(negedge clk);
    #2;
    chk("idle_no_valid", 32'(nvalid), 32'd0);
    chk("idle_byte", 32'(rx_byte), 32'h00);
    cs_low(); send_bits(8'hAF, 1'b0, 8); cs_high(1'b0); settle();
    chk("cmd_af_byte", 32'(rx_byte), 32'hAF);
    chk("cmd_af_on", 32'(display_on), 32'd1);
    chk("cmd_af_count", 32'(cmd_count), 32'd1);
    chk("cmd_af_pulses", 32'(nvalid), 32'd1);
    cs_low();
    send_bits(8'h00, 1'b1, 8); send_bits(8'hFF, 1'b1, 8);
    send_bits(8'hA5, 1'b1, 8); send_bits(8'h5A, 1'b1, 8);
    cs_high(1'b0); settle();
    chk("burst_data_count", 32'(data_count), 32'd4);
    chk("burst_cmd_count", 32'(cmd_count), 32'd1);
    chk("burst_last", 32'(rx_byte), 32'h5A);
    chk("burst_pulses", 32'(nvalid), 32'd5);
    cs_low(); send_bits(8'hF8, 1'b0, 5); cs_high(1'b1); settle();
    chk("ferr_pulses", 32'(nfe), 32'd1);
    chk("ferr_no_valid", 32'(nvalid), 32'd5);
    cs_low(); send_bits(8'hAE, 1'b0, 8); cs_high(1'b0); settle();
    chk("off_byte", 32'(rx_byte), 32'hAE);
    chk("off_display", 32'(display_on), 32'd0);
    chk("off_cmd_count", 32'(cmd_count), 32'd2);
    cs_low(); send_bits(8'h3C, 1'b0, 3);
    @(negedge clk); rst_n = 1'b0; spi_cs = 1'b1; spi_clk = 1'b1; spi_mosi = 1'b0;
    #2;
    chk("reset_clears_count", 32'(cmd_count), 32'd0);
    repeat (5) @(negedge clk); rst_n = 1'b1;
    repeat (4) @(negedge clk);
    cs_low(); send_bits(8'h81, 1'b0, 8); cs_high(1'b0); settle();
    chk("rst_mid_byte", 32'(rx_byte), 32'h81);
    chk("rst_mid_cmd", 32'(cmd_count), 32'd1);
    chk("rst_mid_data", 32'(data_count), 32'd0);
    cs_low();
    for (int i = 0; i < 17; i++) send_bits(8'(i * 13), 1'b1, 8);
    cs_high(1'b0); settle();
    chk("wrap_w4", 32'(data_count4), 32'd1);
    chk("wrap_w16", 32'(data_count), 32'd17);
    chk("wrap_cmd", 32'(cmd_count4), 32'd1);
    repeat (20) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
